mandelbrot_frame_sequencer: RTL and testbench

Frame-level scheduler for the Mandelbrot engine. It walks a COLS×ROWS pixel grid, generates each pixel's cr/ci coordinate and launches one engine run per pixel. Iteration counts go into a 2-entry output FIFO, which the framebuffer writer drains through a valid/ready handshake. It sits between the configuration shift register (start point and step values) and the engine/framebuffer pair, and replaces ad-hoc per-pixel sequencing in the top level.

---
 rtl/mandelbrot_pkg.sv | 30 +++
 rtl/pixel_fifo2.sv | 75 +++++++
 rtl/mandelbrot_frame_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_mandelbrot_frame_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mandelbrot_pkg.sv
// -----------------------------------------------------------------------------
// mandelbrot_pkg
// Shared definitions for the Mandelbrot frame sequencer and its FIFO:
//   - default coordinate / iteration-count widths (match the engine)
//   - signed coordinate typedef at the default width
//   - sequencer state enum
//   - cnt_width(): counter width for a range of n values (never below 1 bit)
// -----------------------------------------------------------------------------
package mandelbrot_pkg;

   localparam int DEF_BITWIDTH = 11;
   localparam int DEF_CTRWIDTH = 7;
   localparam int DEF_COLS     = 80;
   localparam int DEF_ROWS     = 60;

   typedef logic signed [DEF_BITWIDTH-1:0] coord_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT,
      ST_DRAIN,
      ST_ABORT_WAIT
   } seq_state_e;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pixel_fifo2.sv
// -----------------------------------------------------------------------------
// pixel_fifo2
// Two-entry FIFO with a registered head. A push into an empty FIFO shows up
// on valid/head the following cycle. Push and pop may coincide at any
// occupancy; the producer guarantees it never pushes into a full FIFO that
// is not being popped in the same cycle. flush empties the FIFO and wins
// over push/pop.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   push, push_data     write one entry
//   pop                 consumer takes the head (ignored while empty)
//   flush               discard all entries
//   valid, head         head entry present / head entry contents
// -----------------------------------------------------------------------------
module pixel_fifo2 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic             valid,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] tail;
   logic [1:0]       count;
   logic             pop_q;

   assign valid = (count != 2'd0);
   assign pop_q = pop && valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= 2'd0;
         head  <= '0;
         tail  <= '0;
      end else if (flush) begin
         count <= 2'd0;
      end else begin
         unique case ({push, pop_q})
            2'b10: begin
               if (count == 2'd0) head <= push_data;
               else               tail <= push_data;
               count <= count + 2'd1;
            end
            2'b01: begin
               // head keeps its stale value when the last entry leaves
               if (count == 2'd2) head <= tail;
               count <= count - 2'd1;
            end
            2'b11: begin
               // occupancy unchanged; new data goes behind whatever remains
               if (count == 2'd1) begin
                  head <= push_data;
               end else begin
                  head <= tail;
                  tail <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

   // slot reservation upstream must make an overflowing push impossible
   always_ff @(posedge clk) begin
      if (!reset && !flush)
         assert (!(push && !pop_q && count == 2'd2));
   end

endmodule

// File: rtl/mandelbrot_frame_sequencer.sv
// -----------------------------------------------------------------------------
// mandelbrot_frame_sequencer
// Walks a COLS x ROWS pixel grid, launching one engine run per pixel with its
// cr/ci coordinate, and queues iteration counts in a 2-entry FIFO drained by
// the framebuffer writer over a valid/ready handshake.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start                      begin a frame (honoured in IDLE only)
//   abort                      cancel the frame (honoured outside IDLE)
//   cr_start, ci_start         coordinate of pixel (0,0), latched on start
//   cr_step, ci_step           per-column / per-row increments, latched on start
//   eng_run                    one-cycle engine launch
//   eng_cr, eng_ci             coordinate of the in-flight pixel
//   eng_done, eng_ctr          engine result strobe and iteration count
//   pix_valid/data/last/ready  FIFO head handshake to the framebuffer writer
//   busy                       frame in progress
//   frame_done                 pulse when the last pixel of the frame is popped
// -----------------------------------------------------------------------------
module mandelbrot_frame_sequencer
   import mandelbrot_pkg::*;
#(
   parameter int BITWIDTH = DEF_BITWIDTH,
   parameter int CTRWIDTH = DEF_CTRWIDTH,
   parameter int COLS     = DEF_COLS,
   parameter int ROWS     = DEF_ROWS
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       abort,
   input  logic signed [BITWIDTH-1:0] cr_start,
   input  logic signed [BITWIDTH-1:0] ci_start,
   input  logic signed [BITWIDTH-1:0] cr_step,
   input  logic signed [BITWIDTH-1:0] ci_step,
   output logic                       eng_run,
   output logic signed [BITWIDTH-1:0] eng_cr,
   output logic signed [BITWIDTH-1:0] eng_ci,
   input  logic                       eng_done,
   input  logic [CTRWIDTH-1:0]        eng_ctr,
   output logic                       pix_valid,
   output logic [CTRWIDTH-1:0]        pix_data,
   output logic                       pix_last,
   input  logic                       pix_ready,
   output logic                       busy,
   output logic                       frame_done
);

   localparam int CW = cnt_width(COLS);
   localparam int RW = cnt_width(ROWS);
   localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

   seq_state_e state, state_nxt;

   // reserved (engine in flight) plus occupied FIFO entries, 0..2
   logic [1:0] slots, slots_nxt;

   logic signed [BITWIDTH-1:0] cr_start_q, cr_step_q, ci_step_q;
   logic [CW-1:0]              col;
   logic [RW-1:0]              row;

   logic                is_last;
   logic                pop, push, flush, load, advance;
   logic [CTRWIDTH:0]   fifo_head;

   assign is_last = (col == COL_LAST) && (row == ROW_LAST);
   assign pop     = pix_valid && pix_ready;
   assign busy    = (state != ST_IDLE);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         slots <= 2'd0;
      end else begin
         state <= state_nxt;
         slots <= slots_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      eng_run    = 1'b0;
      push       = 1'b0;
      flush      = 1'b0;
      load       = 1'b0;
      advance    = 1'b0;
      frame_done = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            if (abort) begin
               flush     = 1'b1;
               state_nxt = ST_IDLE;
            end else if (slots != 2'd2) begin
               eng_run   = 1'b1;
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (abort) begin
               flush = 1'b1;
               // a result landing in the abort cycle is already the one
               // being discarded, so there is nothing left to wait for
               state_nxt = eng_done ? ST_IDLE : ST_ABORT_WAIT;
            end else if (eng_done) begin
               push = 1'b1;
               if (is_last) begin
                  state_nxt = ST_DRAIN;
               end else begin
                  advance   = 1'b1;
                  state_nxt = ST_LAUNCH;
               end
            end
         end
         ST_DRAIN: begin
            if (abort) begin
               flush     = 1'b1;
               state_nxt = ST_IDLE;
            end else if (pop && pix_last) begin
               frame_done = 1'b1;
               state_nxt  = ST_IDLE;
            end
         end
         ST_ABORT_WAIT: begin
            if (eng_done) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // launch reserves a slot, pop frees one; both together cancel out
   always_comb begin
      slots_nxt = slots;
      if (flush)                slots_nxt = 2'd0;
      else if (eng_run && !pop) slots_nxt = slots + 2'd1;
      else if (!eng_run && pop) slots_nxt = slots - 2'd1;
   end

   // ------------------------------------------------- coordinate walker
   // Coordinates wrap modulo 2^BITWIDTH by plain two's-complement addition.
   always_ff @(posedge clk) begin
      if (reset) begin
         eng_cr     <= '0;
         eng_ci     <= '0;
         cr_start_q <= '0;
         cr_step_q  <= '0;
         ci_step_q  <= '0;
         col        <= '0;
         row        <= '0;
      end else if (load) begin
         eng_cr     <= cr_start;
         eng_ci     <= ci_start;
         cr_start_q <= cr_start;
         cr_step_q  <= cr_step;
         ci_step_q  <= ci_step;
         col        <= '0;
         row        <= '0;
      end else if (advance) begin
         if (col != COL_LAST) begin
            col    <= col + CW'(1);
            eng_cr <= eng_cr + cr_step_q;
         end else begin
            col    <= '0;
            row    <= row + RW'(1);
            eng_cr <= cr_start_q;
            eng_ci <= eng_ci + ci_step_q;
         end
      end
   end

   // ------------------------------------------------------- result FIFO
   pixel_fifo2 #(
      .WIDTH(CTRWIDTH + 1)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .push_data({eng_ctr, is_last}),
      .pop      (pop),
      .flush    (flush),
      .valid    (pix_valid),
      .head     (fifo_head)
   );

   assign pix_data = fifo_head[CTRWIDTH:1];
   assign pix_last = fifo_head[0];

endmodule

// File: tb/tb_mandelbrot_frame_sequencer.sv
module tb_mandelbrot_frame_sequencer;
   import mandelbrot_pkg::*;

   localparam int ENG_LAT = 5;

   logic   clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, pix_ready = 1'b1;
   coord_t cr_start = '0, ci_start = '0, cr_step = '0, ci_step = '0;
   logic   eng_run;
   coord_t eng_cr, eng_ci;
   logic   eng_done = 1'b0;
   logic [6:0] eng_ctr = '0;
   logic   pix_valid, pix_last, busy, frame_done;
   logic [6:0] pix_data;

   int n_cmp = 0, n_err = 0;

   // monitor records (sampled at posedge, i.e. what the DUT itself sees)
   coord_t     mon_cr[$], mon_ci[$];
   logic [7:0] mon_pix[$];
   int         fd_cnt = 0;

   // engine model: fixed latency, count = low 7 bits of (cr + 2*ci)
   int         eng_cnt = 0;
   logic [6:0] pend_ctr = '0;

   mandelbrot_frame_sequencer #(
      .BITWIDTH(11), .CTRWIDTH(7), .COLS(4), .ROWS(2)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .cr_start(cr_start), .ci_start(ci_start), .cr_step(cr_step), .ci_step(ci_step),
      .eng_run(eng_run), .eng_cr(eng_cr), .eng_ci(eng_ci),
      .eng_done(eng_done), .eng_ctr(eng_ctr),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_last(pix_last), .pix_ready(pix_ready),
      .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      eng_done <= 1'b0;
      if (eng_cnt == 1) begin
         eng_done <= 1'b1;
         eng_ctr  <= pend_ctr;
      end
      if (eng_cnt > 0) eng_cnt <= eng_cnt - 1;
      if (eng_run) begin
         eng_cnt  <= ENG_LAT;
         pend_ctr <= 7'(eng_cr + 2 * eng_ci);
      end
   end

   always @(posedge clk) begin
      if (!reset) begin
         if (eng_run) begin
            mon_cr.push_back(eng_cr);
            mon_ci.push_back(eng_ci);
         end
         if (pix_valid && pix_ready) mon_pix.push_back({pix_data, pix_last});
         if (frame_done) fd_cnt++;
      end
   end

   task automatic start_frame(input int a, input int b, input int c, input int d);
      @(negedge clk);
      cr_start = coord_t'(a); cr_step = coord_t'(b);
      ci_start = coord_t'(c); ci_step = coord_t'(d);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (eng_run !== 1'b0)    begin n_err++; $display("FAIL rst_eng_run got %b want 0", eng_run); end
      n_cmp++; if (pix_valid !== 1'b0)  begin n_err++; $display("FAIL rst_pix_valid got %b want 0", pix_valid); end
      n_cmp++; if (pix_last !== 1'b0)   begin n_err++; $display("FAIL rst_pix_last got %b want 0", pix_last); end
      n_cmp++; if (pix_data !== 7'd0)   begin n_err++; $display("FAIL rst_pix_data got %0d want 0", pix_data); end
      n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
      n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL rst_frame_done got %b want 0", frame_done); end
      n_cmp++; if (eng_cr !== 11'sd0)   begin n_err++; $display("FAIL rst_eng_cr got %0d want 0", eng_cr); end
      n_cmp++; if (eng_ci !== 11'sd0)   begin n_err++; $display("FAIL rst_eng_ci got %0d want 0", eng_ci); end
      reset = 1'b0;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL rst_idle_busy got %b want 0", busy); end
   endtask

   task automatic test_frame();
      int exp_cr[8]  = '{-8, -5, -2, 1, -8, -5, -2, 1};
      int exp_ci[8]  = '{5, 5, 5, 5, 3, 3, 3, 3};
      int exp_pix[8] = '{2, 5, 8, 11, 126, 1, 4, 7};
      int base, pbase, fd0;
      bit got;
      pix_ready = 1'b1;
      base = mon_cr.size(); pbase = mon_pix.size(); fd0 = fd_cnt;
      start_frame(-8, 3, 5, -2);
      n_cmp++; if (busy !== 1'b1)     begin n_err++; $display("FAIL frm_start_busy got %b want 1", busy); end
      n_cmp++; if (eng_run !== 1'b1)  begin n_err++; $display("FAIL frm_start_run got %b want 1", eng_run); end
      n_cmp++; if (eng_cr !== -11'sd8) begin n_err++; $display("FAIL frm_start_cr got %0d want -8", eng_cr); end
      n_cmp++; if (eng_ci !== 11'sd5) begin n_err++; $display("FAIL frm_start_ci got %0d want 5", eng_ci); end
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin @(negedge clk); got = eng_done; end
      n_cmp++; if (!got) begin n_err++; $display("FAIL frm_first_done got timeout want eng_done"); end
      @(negedge clk);
      n_cmp++; if (pix_valid !== 1'b1) begin n_err++; $display("FAIL frm_push_lat got %b want 1", pix_valid); end
      n_cmp++; if (eng_run !== 1'b1)   begin n_err++; $display("FAIL frm_relaunch got %b want 1", eng_run); end
      n_cmp++; if (eng_cr !== -11'sd5) begin n_err++; $display("FAIL frm_adv_cr got %0d want -5", eng_cr); end
      for (int i = 0; i < 300 && fd_cnt == fd0; i++) @(negedge clk);
      n_cmp++; if (fd_cnt == fd0) begin n_err++; $display("FAIL frm_timeout got no frame_done want 1"); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL frm_end_busy got %b want 0", busy); end
      repeat (5) @(negedge clk);
      n_cmp++; if (fd_cnt - fd0 != 1) begin n_err++; $display("FAIL frm_fd_count got %0d want 1", fd_cnt - fd0); end
      n_cmp++; if (mon_cr.size() - base != 8) begin n_err++; $display("FAIL frm_launches got %0d want 8", mon_cr.size() - base); end
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (base + i >= mon_cr.size()) begin
            n_err++; $display("FAIL frm_coord[%0d] got missing want %0d/%0d", i, exp_cr[i], exp_ci[i]);
         end else if (mon_cr[base+i] !== coord_t'(exp_cr[i]) || mon_ci[base+i] !== coord_t'(exp_ci[i])) begin
            n_err++; $display("FAIL frm_coord[%0d] got %0d/%0d want %0d/%0d", i, mon_cr[base+i], mon_ci[base+i], exp_cr[i], exp_ci[i]);
         end
         n_cmp++;
         if (pbase + i >= mon_pix.size()) begin
            n_err++; $display("FAIL frm_pix[%0d] got missing want %0d", i, exp_pix[i]);
         end else if (mon_pix[pbase+i] !== {7'(exp_pix[i]), (i == 7)}) begin
            n_err++; $display("FAIL frm_pix[%0d] got %0d last %b want %0d last %b", i, mon_pix[pbase+i][7:1], mon_pix[pbase+i][0], exp_pix[i], (i == 7));
         end
      end
   endtask

   task automatic test_ignored();
      int base, fd0;
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_cmp++; if (busy !== 1'b0)    begin n_err++; $display("FAIL ign_abort_busy got %b want 0", busy); end
      n_cmp++; if (eng_run !== 1'b0) begin n_err++; $display("FAIL ign_abort_run got %b want 0", eng_run); end
      base = mon_cr.size(); fd0 = fd_cnt;
      start_frame(-8, 3, 5, -2);
      repeat (10) @(negedge clk);
      cr_start = 11'sd100; start = 1'b1;
      @(negedge clk);
      start = 1'b0; cr_start = -11'sd8;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ign_start_busy got %b want 1", busy); end
      for (int i = 0; i < 300 && fd_cnt == fd0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      n_cmp++; if (fd_cnt - fd0 != 1) begin n_err++; $display("FAIL ign_fd_count got %0d want 1", fd_cnt - fd0); end
      n_cmp++; if (mon_cr.size() - base != 8) begin n_err++; $display("FAIL ign_launches got %0d want 8", mon_cr.size() - base); end
      n_cmp++;
      if (base + 4 >= mon_cr.size()) begin n_err++; $display("FAIL ign_row1_cr got missing want -8"); end
      else if (mon_cr[base+4] !== -11'sd8) begin n_err++; $display("FAIL ign_row1_cr got %0d want -8", mon_cr[base+4]); end
   endtask

   task automatic test_back_pressure();
      int exp_pix[8] = '{2, 5, 8, 11, 126, 1, 4, 7};
      int base, pbase, fd0;
      bit got;
      base = mon_cr.size(); pbase = mon_pix.size(); fd0 = fd_cnt;
      pix_ready = 1'b0;
      start_frame(-8, 3, 5, -2);
      for (int i = 0; i < 60 && mon_cr.size() - base < 2; i++) @(negedge clk);
      repeat (30) @(negedge clk);
      n_cmp++; if (mon_cr.size() - base != 2) begin n_err++; $display("FAIL bp_stall_launches got %0d want 2", mon_cr.size() - base); end
      n_cmp++; if (pix_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid got %b want 1", pix_valid); end
      n_cmp++; if (pix_data !== 7'd2)  begin n_err++; $display("FAIL bp_head got %0d want 2", pix_data); end
      n_cmp++; if (pix_last !== 1'b0)  begin n_err++; $display("FAIL bp_last got %b want 0", pix_last); end
      pix_ready = 1'b1;
      @(negedge clk);
      pix_ready = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin @(negedge clk); got = eng_done; end
      n_cmp++; if (!got) begin n_err++; $display("FAIL bp_done_wait got timeout want eng_done"); end
      // push and pop land on the same edge here
      pix_ready = 1'b1;
      for (int i = 0; i < 300 && fd_cnt == fd0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      n_cmp++; if (fd_cnt - fd0 != 1) begin n_err++; $display("FAIL bp_fd_count got %0d want 1", fd_cnt - fd0); end
      n_cmp++; if (mon_pix.size() - pbase != 8) begin n_err++; $display("FAIL bp_pops got %0d want 8", mon_pix.size() - pbase); end
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (pbase + i >= mon_pix.size()) begin
            n_err++; $display("FAIL bp_pix[%0d] got missing want %0d", i, exp_pix[i]);
         end else if (mon_pix[pbase+i] !== {7'(exp_pix[i]), (i == 7)}) begin
            n_err++; $display("FAIL bp_pix[%0d] got %0d last %b want %0d last %b", i, mon_pix[pbase+i][7:1], mon_pix[pbase+i][0], exp_pix[i], (i == 7));
         end
      end
   endtask

   task automatic test_wrap();
      int exp_cr[5] = '{1020, -1018, -1008, -998, 1020};
      int base, fd0;
      pix_ready = 1'b1;
      base = mon_cr.size(); fd0 = fd_cnt;
      start_frame(1020, 10, 0, 0);
      for (int i = 0; i < 300 && fd_cnt == fd0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      n_cmp++; if (fd_cnt - fd0 != 1) begin n_err++; $display("FAIL wrap_fd_count got %0d want 1", fd_cnt - fd0); end
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (base + i >= mon_cr.size()) begin
            n_err++; $display("FAIL wrap_cr[%0d] got missing want %0d", i, exp_cr[i]);
         end else if (mon_cr[base+i] !== coord_t'(exp_cr[i])) begin
            n_err++; $display("FAIL wrap_cr[%0d] got %0d want %0d", i, mon_cr[base+i], exp_cr[i]);
         end
      end
   endtask

   task automatic test_abort_wait();
      int base, pbase, fd0;
      bit got;
      base = mon_cr.size(); pbase = mon_pix.size(); fd0 = fd_cnt;
      pix_ready = 1'b0;
      start_frame(-8, 3, 5, -2);
      for (int i = 0; i < 60 && mon_cr.size() - base < 2; i++) @(negedge clk);
      n_cmp++; if (pix_valid !== 1'b1) begin n_err++; $display("FAIL abt_pre_valid got %b want 1", pix_valid); end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_cmp++; if (pix_valid !== 1'b0) begin n_err++; $display("FAIL abt_flush got %b want 0", pix_valid); end
      n_cmp++; if (busy !== 1'b1)      begin n_err++; $display("FAIL abt_wait_busy got %b want 1", busy); end
      got = eng_done;
      for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = eng_done; end
      n_cmp++; if (!got) begin n_err++; $display("FAIL abt_done_wait got timeout want eng_done"); end
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL abt_busy_drop got %b want 0", busy); end
      n_cmp++; if (pix_valid !== 1'b0) begin n_err++; $display("FAIL abt_discard got %b want 0", pix_valid); end
      repeat (3) @(negedge clk);
      n_cmp++; if (fd_cnt != fd0) begin n_err++; $display("FAIL abt_no_fd got %0d want 0", fd_cnt - fd0); end
      n_cmp++; if (mon_pix.size() != pbase) begin n_err++; $display("FAIL abt_no_pop got %0d want 0", mon_pix.size() - pbase); end
      pix_ready = 1'b1;
   endtask

   task automatic test_reset_mid();
      pix_ready = 1'b1;
      start_frame(-8, 3, 5, -2);
      n_cmp++; if (eng_run !== 1'b1) begin n_err++; $display("FAIL rmid_start_run got %b want 1", eng_run); end
      repeat (12) @(negedge clk);
      n_cmp++; if (pix_data !== 7'd2) begin n_err++; $display("FAIL rmid_pre_data got %0d want 2", pix_data); end
      reset = 1'b1;
      @(negedge clk);
      n_cmp++; if (eng_run !== 1'b0)    begin n_err++; $display("FAIL rmid_eng_run got %b want 0", eng_run); end
      n_cmp++; if (pix_valid !== 1'b0)  begin n_err++; $display("FAIL rmid_pix_valid got %b want 0", pix_valid); end
      n_cmp++; if (pix_data !== 7'd0)   begin n_err++; $display("FAIL rmid_pix_data got %0d want 0", pix_data); end
      n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL rmid_busy got %b want 0", busy); end
      n_cmp++; if (eng_cr !== 11'sd0)   begin n_err++; $display("FAIL rmid_eng_cr got %0d want 0", eng_cr); end
      n_cmp++; if (eng_ci !== 11'sd0)   begin n_err++; $display("FAIL rmid_eng_ci got %0d want 0", eng_ci); end
      reset = 1'b0;
      repeat (15) @(negedge clk);
      n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL rmid_late_busy got %b want 0", busy); end
      n_cmp++; if (pix_valid !== 1'b0) begin n_err++; $display("FAIL rmid_late_valid got %b want 0", pix_valid); end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_ignored();
      test_back_pressure();
      test_wrap();
      test_abort_wait();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "watchdog");
   end

endmodule
